// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator driving the data port of the single-cycle-read RAM.
// Optional macro LSU_MISALIGN_SPLIT_EN: doubleword-crossing accesses split into two beats.
module lsu_mem_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic        mem_rd_ena,
  output logic        mem_wr_ena,
  output logic [7:0]  byte_enable,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wr_data,
  input  logic [63:0] mem_rd_data,
  output logic [1:0]  dbg_state
);

  // Handshakes: req_* and resp_* transfer on a rising edge where valid && ready;
  // a valid side holds its payload stable until that edge.

  localparam int REG_BUS = 64;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t                 state;
  logic [REG_BUS-1:0]     addr_q;
  logic [2*REG_BUS-1:0]   wdata_sh_q;
  logic                   wen_q;
  logic [1:0]             size_q;
  logic                   uns_q;
  logic [15:0]            mask_q;
  logic                   err_q;
  logic [REG_BUS-1:0]     lo_q;
  logic [REG_BUS-1:0]     hi_q;

  logic [7:0]             lane_mask_c;
  logic                   misalign_c;
  logic [15:0]            mask_c;
  logic [2*REG_BUS-1:0]   wdata_sh_c;

  always_comb begin
    lane_mask_c = 8'h00;
    misalign_c  = 1'b0;
    unique case (req_size)
      2'd0: lane_mask_c = 8'h01;
      2'd1: begin lane_mask_c = 8'h03; misalign_c = req_addr[0];    end
      2'd2: begin lane_mask_c = 8'h0F; misalign_c = |req_addr[1:0]; end
      default: begin lane_mask_c = 8'hFF; misalign_c = |req_addr[2:0]; end
    endcase
`ifdef LSU_MISALIGN_SPLIT_EN
    misalign_c = 1'b0;
`endif
  end

  assign mask_c     = {8'h00, lane_mask_c} << req_addr[2:0];
  assign wdata_sh_c = {64'h0, req_wdata} << {req_addr[2:0], 3'b000};

  // A rejected access still passes through BEAT0 with all enables off, so its
  // response lands on the same edge as an aligned single-beat access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_sh_q <= '0;
      wen_q      <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      mask_q     <= '0;
      err_q      <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_sh_q <= wdata_sh_c;
            wen_q      <= req_wen;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            mask_q     <= mask_c;
            err_q      <= misalign_c;
            lo_q       <= '0;
            hi_q       <= '0;
            state      <= BEAT0;
          end
        end
        BEAT0: begin
          if (!wen_q && !err_q) lo_q <= mem_rd_data;
`ifdef LSU_MISALIGN_SPLIT_EN
          state <= (!err_q && (mask_q[15:8] != 8'h00)) ? BEAT1 : RESP;
`else
          state <= RESP;
`endif
        end
        BEAT1: begin
          if (!wen_q) hi_q <= mem_rd_data;
          state <= RESP;
        end
        default: begin
          if (resp_ready) state <= IDLE;
        end
      endcase
    end
  end

  logic               beat0;
  logic               beat1;
  logic               active;
  logic [REG_BUS-1:0] dw_addr;
  logic [REG_BUS-1:0] shifted;
  logic [REG_BUS-1:0] load_ext;

  assign beat0   = (state == BEAT0) && !err_q;
  assign beat1   = (state == BEAT1);
  assign active  = beat0 || beat1;
  assign dw_addr = {addr_q[63:3], 3'b000};

  assign mem_rd_ena  = active && !wen_q;
  assign mem_wr_ena  = active && wen_q;
  assign byte_enable = beat1 ? mask_q[15:8] : (beat0 ? mask_q[7:0] : 8'h00);
  assign mem_addr    = beat1 ? dw_addr + 64'd8 : (beat0 ? dw_addr : '0);
  assign mem_wr_data = beat1 ? wdata_sh_q[127:64] : (beat0 ? wdata_sh_q[63:0] : '0);

  always_comb begin
    shifted  = 64'({hi_q, lo_q} >> {addr_q[2:0], 3'b000});
    load_ext = shifted;
    unique case (size_q)
      2'd0: load_ext = {{56{~uns_q & shifted[7]}},  shifted[7:0]};
      2'd1: load_ext = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  assign req_ready     = (state == IDLE) && rst_n;
  assign resp_valid    = (state == RESP);
  assign resp_misalign = (state == RESP) && err_q;
  assign resp_rdata    = ((state == RESP) && !wen_q && !err_q) ? load_ext : '0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: randomized bench for lsu_mem_port against a byte-level memory model.
// Follows LSU_MISALIGN_SPLIT_EN the same way the design does.
module tb_lsu_mem_port;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        mem_rd_ena;
  logic        mem_wr_ena;
  logic [7:0]  byte_enable;
  logic [63:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [63:0] mem_rd_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  lsu_mem_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .mem_rd_ena(mem_rd_ena), .mem_wr_ena(mem_wr_ena), .byte_enable(byte_enable),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .dbg_state(dbg_state)
  );

  // RAM: 256-byte window at BASE, combinational read, byte-enabled write on the edge.
  logic [7:0] ram [0:255];
  logic [7:0] ref_mem [0:255];

  always_comb begin
    mem_rd_data = '0;
    if (mem_addr[63:8] == BASE[63:8])
      for (int i = 0; i < 8; i++) mem_rd_data[8*i +: 8] = ram[8'(mem_addr[7:0] + 8'(i))];
  end

  always @(posedge clk) begin
    if (mem_wr_ena && mem_addr[63:8] == BASE[63:8])
      for (int i = 0; i < 8; i++)
        if (byte_enable[i]) ram[8'(mem_addr[7:0] + 8'(i))] <= mem_wr_data[8*i +: 8];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit split_en();
`ifdef LSU_MISALIGN_SPLIT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: access semantics in terms of byte addresses.
  task automatic ref_access(input logic wen, input logic [1:0] size, input logic uns,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            output logic mis, output logic [63:0] rdata, output int lat);
    int n = 1 << size;
    int idx = int'(addr[7:0]);
    mis   = !split_en() && ((addr % 64'(n)) != 0);
    rdata = '0;
    lat   = (!mis && (int'(addr[2:0]) + n > 8)) ? 2 : 1;
    if (mis) return;
    if (wen) begin
      for (int j = 0; j < n; j++) ref_mem[idx + j] = wdata[8*j +: 8];
    end else begin
      for (int j = 0; j < n; j++) rdata[8*j +: 8] = ref_mem[idx + j];
      if (!uns && n < 8 && rdata[8*n-1])
        for (int j = n; j < 8; j++) rdata[8*j +: 8] = 8'hFF;
    end
  endtask

  task automatic check_window(input string tag, input logic [63:0] addr);
    logic [63:0] got_w, exp_w;
    int start = int'(addr[7:0]) & 8'hF8;
    for (int h = 0; h < 2; h++) begin
      for (int j = 0; j < 8; j++) begin
        got_w[8*j +: 8] = ram[start + 8*h + j];
        exp_w[8*j +: 8] = ref_mem[start + 8*h + j];
      end
      check_eq(tag, got_w, exp_w);
    end
  endtask

  // driver: issue one access at a negedge with the DUT idle, return at a negedge idle again
  task automatic do_op(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata, input int hold,
                       output logic [63:0] got_rdata);
    logic        e_mis;
    logic [63:0] e_rdata;
    int          e_lat;
    int          lat;
    int          n = 1 << size;
    logic [7:0]  e_be [2];
    logic [63:0] e_wd [2];
    logic [63:0] lm;
    e_be[0] = '0; e_be[1] = '0; e_wd[0] = '0; e_wd[1] = '0;
    for (int j = 0; j < n; j++) begin
      logic [63:0] ba = addr + 64'(j);
      int b = int'((ba >> 3) - (addr >> 3));
      int lane = int'(ba[2:0]);
      e_be[b][lane] = 1'b1;
      e_wd[b][8*lane +: 8] = wdata[8*j +: 8];
    end
    ref_access(wen, size, uns, addr, wdata, e_mis, e_rdata, e_lat);

    check_eq("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

    lat = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; break; end
      check_eq("beat_req_ready", 64'(req_ready), 64'd0);
      if (e_mis || i > 1) begin
        check_eq("mis_rd_ena", 64'(mem_rd_ena), 64'd0);
        check_eq("mis_wr_ena", 64'(mem_wr_ena), 64'd0);
        check_eq("mis_be", 64'(byte_enable), 64'd0);
      end else begin
        check_eq("beat_rd_ena", 64'(mem_rd_ena), 64'(!wen));
        check_eq("beat_wr_ena", 64'(mem_wr_ena), 64'(wen));
        check_eq("beat_be", 64'(byte_enable), 64'(e_be[i]));
        check_eq("beat_addr", mem_addr, {addr[63:3], 3'b000} + 64'(8 * i));
        if (wen) begin
          for (int k = 0; k < 8; k++) lm[8*k +: 8] = {8{e_be[i][k]}};
          check_eq("beat_wdata", mem_wr_data & lm, e_wd[i]);
        end
      end
    end
    check_eq("resp_latency", 64'(lat), 64'(e_lat));
    got_rdata = resp_rdata;
    check_eq("resp_rdata", resp_rdata, e_rdata);
    check_eq("resp_misalign", 64'(resp_misalign), 64'(e_mis));
    check_eq("resp_no_enable", 64'({mem_rd_ena, mem_wr_ena, byte_enable}), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(resp_valid), 64'd1);
      check_eq("hold_rdata", resp_rdata, e_rdata);
      check_eq("hold_misalign", 64'(resp_misalign), 64'(e_mis));
      check_eq("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_eq("post_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("post_req_ready", 64'(req_ready), 64'd1);
    if (wen || e_mis) check_window("mem_contents", addr);
  endtask

  logic [63:0] r;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v = 8'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_state_idle", 64'(dbg_state), 64'd0);
    check_eq("rst_resp", 64'({resp_valid, resp_misalign}), 64'd0);
    check_eq("rst_rdata", resp_rdata, 64'd0);
    check_eq("rst_enables", 64'({mem_rd_ena, mem_wr_ena, byte_enable}), 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'd0);
    check_eq("rst_mem_wdata", mem_wr_data, 64'd0);

    do_op(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'h1122_3344_5566_7788, 0, r);
    do_op(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'h0, 0, r);
    check_eq("tp_ld_dword", r, 64'h1122_3344_5566_7788);
    do_op(1'b0, 2'd0, 1'b0, 64'h8000_0013, 64'h0, 0, r);
    check_eq("tp_lb_signed", r, 64'h55);
    do_op(1'b1, 2'd0, 1'b0, 64'h8000_0013, 64'h85, 0, r);
    do_op(1'b0, 2'd0, 1'b0, 64'h8000_0013, 64'h0, 0, r);
    check_eq("tp_lb_neg", r, 64'hFFFF_FFFF_FFFF_FF85);
    do_op(1'b0, 2'd0, 1'b1, 64'h8000_0013, 64'h0, 0, r);
    check_eq("tp_lbu", r, 64'h85);
    do_op(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'hBEEF, 0, r);
`ifdef LSU_MISALIGN_SPLIT_EN
    do_op(1'b1, 2'd2, 1'b0, 64'h8000_000E, 64'hDEAD_BEEF, 0, r);
    do_op(1'b0, 2'd2, 1'b1, 64'h8000_000E, 64'h0, 0, r);
    check_eq("tp_lwu_split", r, 64'hDEAD_BEEF);
`endif
    do_op(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'h0, 5, r);

    // reset in the middle of a store
`ifdef LSU_MISALIGN_SPLIT_EN
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h8000_0034; req_wdata = 64'hA1A2_A3A4_A5A6_A7A8;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk);
    for (int j = 0; j < 4; j++) ref_mem[8'h34 + j] = req_wdata[8*j +: 8];
    @(negedge clk);
    check_eq("rstmid_beat1_wr", 64'(mem_wr_ena), 64'd1);
`else
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h8000_0038; req_wdata = 64'hA1A2_A3A4_A5A6_A7A8;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    check_eq("rstmid_beat0_wr", 64'(mem_wr_ena), 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_enables", 64'({mem_rd_ena, mem_wr_ena, byte_enable}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstmid_req_ready", 64'(req_ready), 64'd1);
    check_eq("rstmid_resp_valid", 64'(resp_valid), 64'd0);
    check_window("rstmid_mem", 64'h8000_0038);
    check_window("rstmid_mem_lo", 64'h8000_0030);

    for (int t = 0; t < 300; t++) begin
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [63:0] a = BASE + 64'($urandom_range(0, 8'hE0));
      logic [63:0] wd = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      do_op(1'($urandom), sz, 1'($urandom), a, wd, $urandom_range(0, 2), r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
